// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the instruction/data memory arbiter.
//   - arb_state_e   : arbiter FSM state encoding
//   - STORE_*       : store-type encodings, identical to the core's store_type
//   - DEF_*         : default width / timeout constants for the arbiter
package mem_arb_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 15;

    // Wait counter width; large enough for the full MAX_WAIT range 1..255.
    localparam int WAIT_CNT_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_RESP   = 2'd3
    } arb_state_e;

    // Store types as produced by the core's load/store unit.
    localparam logic [2:0] STORE_NONE = 3'b000;
    localparam logic [2:0] STORE_BYTE = 3'b001;
    localparam logic [2:0] STORE_WORD = 3'b010;
    localparam logic [2:0] STORE_HALF = 3'b100;

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// wait_timer: counts memory busy cycles for the arbiter's timeout.
//   clk      in  clock
//   rst      in  asynchronous active-low reset
//   clear    in  force the count back to 0 (held while the arbiter is idle)
//   count_en in  advance the count by one (busy cycle without m_ack)
//   expired  out count has reached MAX_WAIT-1, i.e. this is the last busy cycle
module wait_timer
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(MAX_WAIT - 1);

    logic [WAIT_CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (count_en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = (cnt_reg == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between an
// instruction read port (i_*) and a data read/write port (d_*).
//   clk, rst                       clock, asynchronous active-low reset
//   i_req/i_addr                   instruction read request
//   i_rdata/i_ack/i_err            instruction response (err valid with ack)
//   d_req/d_we/d_wtype/d_addr/d_wdata   data request
//   d_rdata/d_ack/d_err            data response (err valid with ack)
//   m_req/m_we/m_wtype/m_addr/m_wdata   memory request bundle
//   m_rdata/m_ack                  memory response
//   busy                           arbiter not idle
// Each transaction is IDLE -> BUSY_x -> RESP -> IDLE; a memory that stays
// busy for MAX_WAIT cycles ends the transaction with err=1.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_wtype,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              m_req,
    output logic              m_we,
    output logic [2:0]        m_wtype,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              busy
);

    arb_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [2:0]        wtype_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              gnt_d_reg;   // transaction in flight belongs to the data port
    logic              last_d_reg;  // last grant went to the data port
    logic              err_reg;
    logic [DATA_W-1:0] i_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;

    logic in_busy;
    logic grant_d;
    logic expired;

    assign in_busy = (state_reg == S_BUSY_I) || (state_reg == S_BUSY_D);

    // Data wins when it is the only requester, or on contention when the
    // instruction port was served last.
    assign grant_d = d_req && (!i_req || !last_d_reg);

    wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_reg == S_IDLE),
        .count_en (in_busy && !m_ack),
        .expired  (expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (i_req || d_req) begin
                    state_next = grant_d ? S_BUSY_D : S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                // m_ack takes priority over the timeout on the final cycle.
                if (m_ack || expired) begin
                    state_next = S_RESP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            addr_reg    <= '0;
            we_reg      <= 1'b0;
            wtype_reg   <= STORE_NONE;
            wdata_reg   <= '0;
            gnt_d_reg   <= 1'b0;
            last_d_reg  <= 1'b1;
            err_reg     <= 1'b0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && (i_req || d_req)) begin
                gnt_d_reg  <= grant_d;
                last_d_reg <= grant_d;
                if (grant_d) begin
                    addr_reg  <= d_addr;
                    we_reg    <= d_we;
                    wtype_reg <= d_wtype;
                    wdata_reg <= d_wdata;
                end else begin
                    addr_reg  <= i_addr;
                    we_reg    <= 1'b0;
                    wtype_reg <= STORE_NONE;
                    wdata_reg <= '0;
                end
            end
            if (in_busy) begin
                if (m_ack) begin
                    err_reg <= 1'b0;
                    if (gnt_d_reg) begin
                        d_rdata_reg <= m_rdata;
                    end else begin
                        i_rdata_reg <= m_rdata;
                    end
                end else if (expired) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign busy    = (state_reg != S_IDLE);
    assign m_req   = in_busy;
    assign m_we    = we_reg;
    assign m_wtype = wtype_reg;
    assign m_addr  = addr_reg;
    assign m_wdata = wdata_reg;

    assign i_ack   = (state_reg == S_RESP) && !gnt_d_reg;
    assign d_ack   = (state_reg == S_RESP) && gnt_d_reg;
    assign i_err   = i_ack && err_reg;
    assign d_err   = d_ack && err_reg;
    assign i_rdata = i_rdata_reg;
    assign d_rdata = d_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
// (default parameters: 32-bit address/data, MAX_WAIT = 15).
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_wtype;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [2:0]  m_wtype;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_wtype (d_wtype),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_wtype (m_wtype),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs set afterwards apply to the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_wtype = 0;
        d_addr = 0; d_wdata = 0; m_rdata = 0; m_ack = 0;
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req got=%b exp=0", m_req); end
        total++; if ({i_ack, d_ack, i_err, d_err} !== 4'b0) begin bad++; $display("FAIL reset_acks got=%b exp=0000", {i_ack, d_ack, i_err, d_err}); end
        total++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", i_rdata, d_rdata); end
        total++; if (m_addr !== 32'h0 || m_we !== 1'b0 || m_wdata !== 32'h0) begin bad++; $display("FAIL reset_m_bundle got=%h/%b/%h exp=0", m_addr, m_we, m_wdata); end
        step(); step();
        rst = 1'b1;
        $display("txn reset released");
    endtask

    // Zero-wait instruction read.
    task automatic test_single_read();
        i_req = 1; i_addr = 32'h100;
        step();
        total++; if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0) begin bad++; $display("FAIL rd_busy got=req%b addr%h we%b exp=req1 addr100 we0", m_req, m_addr, m_we); end
        m_ack = 1; m_rdata = 32'hDEADBEEF;
        step();
        total++; if (i_ack !== 1'b1 || i_err !== 1'b0 || d_ack !== 1'b0) begin bad++; $display("FAIL rd_resp got=iack%b ierr%b dack%b exp=1 0 0", i_ack, i_err, d_ack); end
        total++; if (i_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", i_rdata); end
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rd_mreq_resp got=%b exp=0", m_req); end
        // m_ack left high through RESP and IDLE must have no effect.
        i_req = 0; m_rdata = 32'h0BAD0BAD;
        step();
        total++; if (i_ack !== 1'b0 || busy !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_idle got=ack%b busy%b data%h exp=0 0 deadbeef", i_ack, busy, i_rdata); end
        m_ack = 0;
        $display("txn i read addr=00000100 data=%h", i_rdata);
    endtask

    // Both ports requesting right after reset: instruction first.
    task automatic test_contention();
        rst = 0; #2; rst = 1;
        step();
        i_req = 1; i_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2004;
        step();
        total++; if (m_req !== 1'b1 || m_addr !== 32'h1000 || m_we !== 1'b0) begin bad++; $display("FAIL cont_first got=req%b addr%h we%b exp=req1 addr1000 we0", m_req, m_addr, m_we); end
        m_ack = 1; m_rdata = 32'h11111111;
        step();
        total++; if (i_ack !== 1'b1 || d_ack !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL cont_iack got=iack%b dack%b mreq%b exp=1 0 0", i_ack, d_ack, m_req); end
        i_req = 0; m_ack = 0;
        step();
        total++; if (m_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL cont_gap got=mreq%b busy%b exp=0 0", m_req, busy); end
        step();
        total++; if (m_req !== 1'b1 || m_addr !== 32'h2004) begin bad++; $display("FAIL cont_second got=req%b addr%h exp=req1 addr2004", m_req, m_addr); end
        m_ack = 1; m_rdata = 32'h22222222;
        step();
        total++; if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_err !== 1'b0) begin bad++; $display("FAIL cont_dack got=dack%b iack%b derr%b exp=1 0 0", d_ack, i_ack, d_err); end
        total++; if (d_rdata !== 32'h22222222 || i_rdata !== 32'h11111111) begin bad++; $display("FAIL cont_data got=%h/%h exp=22222222/11111111", d_rdata, i_rdata); end
        d_req = 0; m_ack = 0;
        step();
        $display("txn contention i_data=%h d_data=%h", i_rdata, d_rdata);
    endtask

    // Store with three wait cycles before m_ack.
    task automatic test_write_wait();
        int acks = 0;
        d_req = 1; d_we = 1; d_wtype = 3'b010; d_addr = 32'h2000; d_wdata = 32'h12345678;
        m_rdata = 32'hCAFE0001;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (d_ack) acks++;
            total++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'h12345678 || m_wtype !== 3'b010 || m_addr !== 32'h2000) begin bad++; $display("FAIL wr_hold_%0d got=req%b we%b wd%h wt%b addr%h exp=1 1 12345678 010 2000", k, m_req, m_we, m_wdata, m_wtype, m_addr); end
            if (k == 4) m_ack = 1;
        end
        step();
        if (d_ack) acks++;
        total++; if (d_ack !== 1'b1 || d_err !== 1'b0) begin bad++; $display("FAIL wr_resp got=dack%b derr%b exp=1 0", d_ack, d_err); end
        d_req = 0; d_we = 0; m_ack = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (d_ack) acks++;
        end
        total++; if (acks !== 1) begin bad++; $display("FAIL wr_ack_count got=%0d exp=1", acks); end
        total++; if (d_rdata !== 32'hCAFE0001) begin bad++; $display("FAIL wr_rdata got=%h exp=cafe0001", d_rdata); end
        $display("txn d write addr=00002000 wdata=12345678");
    endtask

    // Memory never answers: 15 busy cycles, then error response.
    task automatic test_timeout();
        int mreq_cycles = 0;
        d_req = 1; d_addr = 32'h3000; m_ack = 0; m_rdata = 32'hBAD0BAD0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (m_req === 1'b1) mreq_cycles++;
            total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL to_early_ack_%0d got=%b exp=0", k, d_ack); end
        end
        total++; if (mreq_cycles !== 15) begin bad++; $display("FAIL to_mreq_cycles got=%0d exp=15", mreq_cycles); end
        step();
        total++; if (d_ack !== 1'b1 || d_err !== 1'b1 || m_req !== 1'b0) begin bad++; $display("FAIL to_resp got=dack%b derr%b mreq%b exp=1 1 0", d_ack, d_err, m_req); end
        total++; if (d_rdata !== 32'hCAFE0001) begin bad++; $display("FAIL to_rdata_kept got=%h exp=cafe0001", d_rdata); end
        d_req = 0;
        step();
        total++; if (d_ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_idle got=dack%b busy%b exp=0 0", d_ack, busy); end
        $display("txn d read addr=00003000 timeout err=1");
    endtask

    // m_ack arrives on the final (15th) busy cycle: normal completion.
    task automatic test_late_ack();
        d_req = 1; d_addr = 32'h3004; m_ack = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            total++; if (m_req !== 1'b1) begin bad++; $display("FAIL late_mreq_%0d got=%b exp=1", k, m_req); end
            if (k == 15) begin m_ack = 1; m_rdata = 32'h5A5A5A5A; end
        end
        step();
        total++; if (d_ack !== 1'b1 || d_err !== 1'b0) begin bad++; $display("FAIL late_resp got=dack%b derr%b exp=1 0", d_ack, d_err); end
        total++; if (d_rdata !== 32'h5A5A5A5A) begin bad++; $display("FAIL late_rdata got=%h exp=5a5a5a5a", d_rdata); end
        d_req = 0; m_ack = 0;
        step();
        $display("txn d read addr=00003004 data=%h on last wait cycle", d_rdata);
    endtask

    // Reset during BUSY_D aborts the transaction.
    task automatic test_reset_mid();
        int acks = 0;
        d_req = 1; d_addr = 32'h3008; m_ack = 0;
        step();
        step();
        total++; if (m_req !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", m_req); end
        #2; rst = 0; #1;
        total++; if (m_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_async got=mreq%b busy%b exp=0 0", m_req, busy); end
        total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", d_rdata); end
        d_req = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (d_ack) acks++;
        end
        rst = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (d_ack) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks); end
        d_req = 1; d_addr = 32'h4000;
        step();
        total++; if (m_req !== 1'b1 || m_addr !== 32'h4000) begin bad++; $display("FAIL rstmid_fresh got=req%b addr%h exp=req1 addr4000", m_req, m_addr); end
        m_ack = 1; m_rdata = 32'h00000077;
        step();
        total++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h77) begin bad++; $display("FAIL rstmid_fresh_resp got=dack%b derr%b data%h exp=1 0 00000077", d_ack, d_err, d_rdata); end
        d_req = 0; m_ack = 0;
        step();
        $display("txn reset abort then d read addr=00004000 data=%h", d_rdata);
    endtask

    // Zero-wait memory, both ports streaming: one transaction per 3 cycles,
    // grants alternate. Last grant before this test went to the data port.
    task automatic test_back_to_back();
        i_req = 1; i_addr = 32'h500; d_req = 1; d_addr = 32'h600; d_we = 0;
        m_ack = 1; m_rdata = 32'h0000ABCD;
        for (int k = 1; k <= 9; k++) begin
            step();
            total++; if (i_ack !== (k == 2 || k == 8) || d_ack !== (k == 5)) begin bad++; $display("FAIL b2b_ack_%0d got=iack%b dack%b exp=%b %b", k, i_ack, d_ack, (k == 2 || k == 8), (k == 5)); end
            if (k == 1 || k == 7) begin
                total++; if (m_addr !== 32'h500) begin bad++; $display("FAIL b2b_addr_%0d got=%h exp=00000500", k, m_addr); end
            end
            if (k == 4) begin
                total++; if (m_addr !== 32'h600) begin bad++; $display("FAIL b2b_addr_%0d got=%h exp=00000600", k, m_addr); end
            end
            if (k == 5) d_req = 0;
            if (k == 8) i_req = 0;
        end
        m_ack = 0;
        $display("txn back-to-back i/d/i completed");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_wait();
        test_timeout();
        test_late_ack();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of busy cycles allowed before a memory timeout (legal range 1..255).
REQ-004 The block SHALL have one clock, clk; reset is asynchronous and active-low, named rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 i_req / i_addr  in  1 / ADDR_W  instruction-port read request and address.
REQ-008 i_rdata / i_ack / i_err  out  DATA_W / 1 / 1  instruction read data, one-cycle completion pulse, error flag qualified by i_ack.
REQ-009 d_req / d_we / d_wtype / d_addr / d_wdata  in  1 / 1 / 3 / ADDR_W / DATA_W  data-port request, write enable, store type, address, write data.
REQ-010 d_rdata / d_ack / d_err  out  DATA_W / 1 / 1  data read data, completion pulse, error flag qualified by d_ack.
REQ-011 m_req / m_we / m_wtype / m_addr / m_wdata  out  1 / 1 / 3 / ADDR_W / DATA_W  shared single-port memory request bundle.
REQ-012 m_rdata / m_ack  in  DATA_W / 1  memory read data, completion accepted in the same cycle it is high.
REQ-013 busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY_I, BUSY_D and RESP.
REQ-015 In IDLE, the FSM SHALL move to BUSY_I or BUSY_D at the next edge if any request is pending, latching that port's address, write enable, store type and write data.
- The instruction port is latched with write enable 0 and store type 0.
REQ-016 Arbitration SHALL be as follows:
- A single pending request wins.
- If both are pending, the port not granted last wins (round-robin).
- A last_d flag records the last port granted.
REQ-017 m_req SHALL be high only in BUSY_I/BUSY_D, with m_* driven from the latched registers and held stable until the state is left.
REQ-018 In BUSY, if m_ack is high, the FSM SHALL capture m_rdata into the granted port's rdata register and go to RESP with err=0.
REQ-019 The wait counter SHALL clear on entering BUSY and increment on each BUSY cycle without m_ack.
- If the counter equals MAX_WAIT-1 and m_ack is low, the FSM goes to RESP with err=1 and rdata unchanged.
REQ-020 If m_ack coincides with the final wait cycle, the transaction SHALL complete normally with err=0.
REQ-021 In RESP, the granted port's ack SHALL be high for exactly one cycle, and its err SHALL be valid.
- No arbitration occurs in RESP.
- The next state is IDLE.
REQ-022 Requesters SHALL hold req and payload stable until ack.
- A req still high in the IDLE cycle after ack is treated as a new request.
REQ-023 m_ack received in IDLE or RESP SHALL be ignored.
REQ-024 Latency with zero-wait memory: the ack SHALL be high 2 cycles after the cycle the req is sampled in IDLE, with one transaction per 3 cycles.
REQ-025 rdata outputs SHALL hold their last captured value between transactions.

Reset
REQ-026 When rst is low, the state SHALL become IDLE asynchronously and all outputs SHALL become 0.
- The counter resets to 0.
- last_d resets to 1, so the instruction port wins the first contention.
REQ-027 Reset asserted mid-transaction SHALL drop m_req immediately, issue no ack, and discard the transaction.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum, store-type encodings (shared with the core's store_type) and default width constants.
REQ-029 The timeout counter SHALL be a sub-module named wait_timer (inputs: clear, count_en; output: expired).

Verification
REQ-030 i_req=1, i_addr=0x100 in c0, m_ack=1 and m_rdata=0xDEADBEEF in c1 -> m_req=1, m_addr=0x100, m_we=0 in c1; i_ack=1, i_rdata=0xDEADBEEF, i_err=0 in c2.
REQ-031 i_req and d_req both high after reset, held until their acks -> instruction granted first, data second; m_addr order i_addr then d_addr; no overlap of m_req.
REQ-032 d_we=1, d_wtype=3'b010, d_addr=0x2000, d_wdata=0x12345678, m_ack after 3 wait cycles -> m_we=1 and m_wdata=0x12345678 stable for 4 cycles; d_ack pulse once.
REQ-033 MAX_WAIT=15, d_req with m_ack never high -> m_req high for 15 cycles, then d_ack=1 and d_err=1 one cycle later, m_req=0.
REQ-034 m_ack on the 15th busy cycle -> d_err=0, and d_rdata captures m_rdata.
REQ-035 rst low during BUSY_D -> m_req=0 immediately, no d_ack ever, busy=0; after release, a fresh d_req completes normally.
